rs_enc_arbiter: RTL and testbench

//   Shares one rs_encoder_0 instance between N_CH byte-stream requesters in the core_clk domain.

---
 rtl/rs_enc_arbiter.sv | 88 ++++++++
 tb/tb_rs_enc_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rs_enc_arbiter.sv
// rs_enc_arbiter: round-robin arbiter that grants one RS encoder to one channel per K_BYTES message.
// Optional statistics counters are enabled by defining RS_ARB_STATS_EN.
module rs_enc_arbiter #(
  parameter int N_CH = 4,
  parameter int K_BYTES = 229,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH*8-1:0] s_tdata,
  input  logic [N_CH-1:0]   s_tvalid,
  output logic [N_CH-1:0]   s_tready,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [CH_W-1:0]   m_tuser,
  output logic              busy,
  output logic [CH_W-1:0]   cur_ch
`ifdef RS_ARB_STATS_EN
  ,
  output logic [N_CH*16-1:0] blk_cnt,
  output logic [31:0]        stall_cnt
`endif
);
  localparam int BW = (K_BYTES > 1) ? $clog2(K_BYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(K_BYTES - 1);
  localparam logic [CH_W-1:0] MAX_CH = CH_W'(N_CH - 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nx;
  logic [BW-1:0] byte_cnt;
  logic [CH_W-1:0] rr_ptr, gnt;
  logic [N_CH-1:0] req;
  logic xfer, hs, done;
  int j;
  assign req = ch_en & s_tvalid;
  assign xfer = state == XFER;
  assign hs = m_tvalid & m_tready;
  assign done = hs & (byte_cnt == LAST);
  // round-robin pick: scan from the farthest offset down so the nearest request at/after rr_ptr wins
  always_comb begin
    gnt = '0;
    j = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (req[CH_W'(j)]) gnt = CH_W'(j);
    end
  end
  // state register
  always_ff @(posedge core_clk) state <= !rst_n ? IDLE : state_nx;
  // next state: grant on any request, release only after the last byte's handshake
  always_comb state_nx = xfer ? (done ? IDLE : XFER) : (|req ? XFER : IDLE);
  // outputs: granted channel routed straight to the encoder, everything quiet while idle
  always_comb begin
    m_tdata = xfer ? s_tdata[{cur_ch, 3'b000} +: 8] : '0;
    m_tvalid = xfer & s_tvalid[cur_ch];
    s_tready = xfer ? (N_CH'(m_tready) << cur_ch) : '0;
    m_tlast = xfer & (byte_cnt == LAST);
    m_tuser = xfer ? cur_ch : '0;
    busy = xfer;
  end
  // grant register, round-robin pointer and beat counter
  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      cur_ch <= '0;
      rr_ptr <= '0;
      byte_cnt <= '0;
    end else begin
      if (!xfer && |req) cur_ch <= gnt;
      if (hs) byte_cnt <= done ? '0 : byte_cnt + 1'b1;
      if (done) rr_ptr <= (cur_ch == MAX_CH) ? '0 : cur_ch + 1'b1;
    end
  end
`ifdef RS_ARB_STATS_EN
  // per-channel completed-message counters (wrapping) and saturating stall counter
  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (done) blk_cnt[{cur_ch, 4'b0000} +: 16] <= blk_cnt[{cur_ch, 4'b0000} +: 16] + 16'd1;
      if (xfer && !m_tvalid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rs_enc_arbiter.sv
// tb_rs_enc_arbiter: directed bench for rs_enc_arbiter with a per-channel byte scoreboard.
module tb_rs_enc_arbiter;
  localparam int K = 229;
  logic core_clk = 0;
  logic rst_n = 0;
  logic [3:0] ch_en = 0;
  logic [3:0] s_tvalid = 0;
  logic [31:0] s_tdata;
  logic [3:0] s_tready;
  logic [7:0] m_tdata;
  logic m_tvalid;
  logic m_tready = 0;
  logic m_tlast;
  logic [1:0] m_tuser;
  logic busy;
  logic [1:0] cur_ch;
`ifdef RS_ARB_STATS_EN
  logic [63:0] blk_cnt;
  logic [31:0] stall_cnt;
`endif
  int errors = 0;
  int checks = 0;
  logic [7:0] src [4];
  logic [7:0] exp_idx [4];

  always #5 core_clk = ~core_clk;
  assign s_tdata = {src[3] + 8'hC0, src[2] + 8'h80, src[1] + 8'h40, src[0]};

  rs_enc_arbiter dut (
    .core_clk(core_clk), .rst_n(rst_n), .ch_en(ch_en), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy), .cur_ch(cur_ch)
`ifdef RS_ARB_STATS_EN
    , .blk_cnt(blk_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: sources pop the byte their s_tready accepted at the edge
  task automatic tick;
    logic [3:0] pop;
    #1;
    pop = s_tready & s_tvalid;
    @(posedge core_clk);
    for (int i = 0; i < 4; i++) if (pop[i]) src[i] = src[i] + 8'd1;
    #1;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_sready"}, s_tready, 0);
    chk({tag, "_tuser"}, m_tuser, 0);
  endtask

  // mode 0 plain, 1 m_tready toggling, 2 source gap at beat 100, 3 reset at beat 50
  task automatic msg(input int ch, input int mode, input logic [3:0] en_mid);
    int k;
    int cyc;
    int gap;
    logic v;
    logic [7:0] e;
    k = 0;
    cyc = 0;
    gap = 0;
    #1;
    chk("pre_busy", busy, 0);
    tick;
    chk("grant", cur_ch, ch);
    chk("busy", busy, 1);
    ch_en = en_mid;
    while (k < K && cyc < 3000) begin
      if (mode == 3 && k == 50) begin
        m_tready = 0;
        rst_n = 0;
        tick;
        rst_n = 1;
        m_tready = 1;
        #1;
        quiet("rst");
        chk("rst_cur_ch", cur_ch, 0);
        return;
      end
      m_tready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      v = !(mode == 2 && k == 100 && gap < 10);
      if (!v) gap++;
      s_tvalid[ch] = v;
      #1;
      chk("tvalid", m_tvalid, v);
      chk("sready", s_tready, m_tready ? (4'b0001 << ch) : 4'b0000);
      chk("tlast", m_tlast, k == K - 1);
      chk("tuser", m_tuser, ch);
      if (v && m_tready) begin
        e = exp_idx[ch] + 8'(ch * 64);
        chk("data", m_tdata, e);
        exp_idx[ch] = exp_idx[ch] + 8'd1;
        k++;
      end
      tick;
      cyc++;
    end
    chk("end_busy", busy, 0);
    chk("end_tvalid", m_tvalid, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src[i] = 0;
      exp_idx[i] = 0;
    end
    ch_en = 4'b0001;
    s_tvalid = 4'b0001;
    m_tready = 1;
    tick;
    tick;
    quiet("reset");
    chk("reset_cur_ch", cur_ch, 0);
    rst_n = 1;
    msg(0, 0, 4'b0001);
    msg(0, 0, 4'b0001);
    ch_en = 4'b0100;
    s_tvalid = 4'b1111;
    msg(2, 2, 4'b0010);
    msg(1, 1, 4'b0010);
    msg(1, 3, 4'b0010);
    ch_en = 4'b1111;
    for (int i = 0; i < 8; i++) msg(i % 4, 0, 4'b1111);
`ifdef RS_ARB_STATS_EN
    for (int i = 0; i < 4; i++) chk("blk_cnt", blk_cnt[16*i +: 16], 2);
    chk("stall_cnt", stall_cnt, 0);
`endif
    msg(0, 0, 4'b1111);
    ch_en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("norq_busy", busy, 0);
    end
    ch_en = 4'b1111;
    msg(1, 0, 4'b1111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
